// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
//   Instruction-fetch stage with a small prefetch queue. Sequential word
//   fetches go out over a req/rsp interface to instruction memory. Returned
//   words are stored with their PC in a FIFO and handed to decode through a
//   valid/ready handshake. A redirect flushes the FIFO, restarts fetching at
//   the new target and drops every response still in flight from before it.
//
// Ports
//   clk, rst_n        clock (posedge) / asynchronous active-low reset
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         word-aligned fetch byte address
//   imem_rsp_valid    response word valid (in request order, latency >= 1)
//   imem_rdata        response instruction word
//   redirect_valid    flush and restart at redirect_pc
//   redirect_pc       new fetch address, bits [1:0] ignored
//   dec_valid         head entry valid
//   dec_ready         decode consumes the head entry
//   dec_instr         head instruction
//   dec_pc            PC of the head instruction
//   perf_stall_cnt    cycles with dec_ready=1 and dec_valid=0
//
// Build option
//   IF_PREFETCH_PERF_EN  when defined, perf_stall_cnt is a saturating
//                        counter; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module if_prefetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] perf_stall_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Sequential state
  logic          run_reg;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [OW-1:0] out_reg;
  logic [OW-1:0] discard_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   instr_mem[DEPTH];

  // Next-state values
  logic [31:0]   fetch_pc_next;
  logic [31:0]   rsp_pc_next;
  logic [OW-1:0] out_next;
  logic [OW-1:0] discard_next;
  logic [CW-1:0] count_next;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;

  logic [31:0]   redirect_pc_al;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Masking keeps every input bit in use while forcing word alignment.
  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

  // Entries already buffered plus words still owed by memory must fit in
  // the FIFO, so a response can always be accepted without back-pressure.
  assign occupancy = {1'b0, count_reg} + (CW+1)'(out_reg);

  // run_reg keeps requests off while reset is asserted and for the first
  // edge after release.
  assign imem_req_valid = run_reg && !redirect_valid &&
                          (occupancy < (CW+1)'(DEPTH)) &&
                          (out_reg < OW'(MAX_OUTSTANDING));
  assign imem_addr      = fetch_pc_reg;

  assign issue = imem_req_valid && imem_req_ready;
  assign push  = imem_rsp_valid && !redirect_valid && (discard_reg == '0);
  assign pop   = dec_valid && dec_ready && !redirect_valid;

  // Head is read from registered storage only; a response written at the
  // end of cycle N is first visible in cycle N+1.
  assign dec_valid = (count_reg != '0);
  assign dec_instr = instr_mem[rd_ptr_reg];
  assign dec_pc    = pc_mem[rd_ptr_reg];

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    out_next      = out_reg;
    discard_next  = discard_reg;
    count_next    = count_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;

    // Outstanding tracks requests regardless of redirects; a same-cycle
    // issue and response cancel out.
    if (issue && !imem_rsp_valid) begin
      out_next = out_reg + OW'(1);
    end else if (!issue && imem_rsp_valid) begin
      out_next = out_reg - OW'(1);
    end

    if (redirect_valid) begin
      fetch_pc_next = redirect_pc_al;
      rsp_pc_next   = redirect_pc_al;
      // Everything still owed by memory is stale; a response arriving in
      // this very cycle is already dropped, so it is not counted again.
      discard_next  = out_reg - OW'(imem_rsp_valid);
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      if (issue) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (imem_rsp_valid && (discard_reg != '0)) begin
        discard_next = discard_reg - OW'(1);
      end
      if (push) begin
        rsp_pc_next = rsp_pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (!push && pop) begin
        count_next = count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg      <= 1'b0;
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      out_reg      <= '0;
      discard_reg  <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      run_reg      <= 1'b1;
      fetch_pc_reg <= fetch_pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      out_reg      <= out_next;
      discard_reg  <= discard_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // FIFO storage, one register pair per entry so the head reads back as
  // zero straight out of reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc_mem[gi]    <= '0;
          instr_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          pc_mem[gi]    <= rsp_pc_reg;
          instr_mem[gi] <= imem_rdata;
        end
      end
    end
  endgenerate

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg <= '0;
    end else if (dec_ready && !dec_valid && (perf_reg != 32'hFFFF_FFFF)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_reg;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
